// File: rtl/execute_unit_if.sv
// Bundle/handshake, regbank write port and status signals between execute_unit and its neighbours.
interface execute_unit_if;
  logic        readyIn;
  logic        triggerOut;
  logic [31:0] dataIn1;
  logic [31:0] dataIn2;
  logic [31:0] dataIn3;
  logic [31:0] dataIn4;
  logic [3:0]  typeIn;
  logic [31:0] srcDstIn;
  logic        triggerOutW;
  logic [31:0] addrW;
  logic [31:0] dataW;
  logic        readyInW;
  logic [31:0] cpsrOut;
  logic        cpsrValid;
  logic        busy;
  logic        errOut;

  modport slave (
    input  readyIn, dataIn1, dataIn2, dataIn3, dataIn4, typeIn, srcDstIn, readyInW,
    output triggerOut, triggerOutW, addrW, dataW, cpsrOut, cpsrValid, busy, errOut
  );

  modport master (
    output readyIn, dataIn1, dataIn2, dataIn3, dataIn4, typeIn, srcDstIn, readyInW,
    input  triggerOut, triggerOutW, addrW, dataW, cpsrOut, cpsrValid, busy, errOut
  );
endinterface

// File: rtl/execute_unit.sv
// Execute stage: ARM data-processing ALU and 32-cycle shift-add multiply behind a
// synchronized level-ready/toggle handshake, with a toggle write port to the regbank.
module execute_unit #(
  parameter int SYNC_STAGES = 2,
  parameter bit MUL_ENABLE  = 1'b1
) (
  input logic           clk,
  input logic           reset,
  execute_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, WB_WAIT} state_t;

  localparam logic [3:0] TYPE_NOP = 4'h0;
  localparam logic [3:0] TYPE_DP  = 4'h1;
  localparam logic [3:0] TYPE_MUL = 4'h2;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] readySync_q, ackSync_q;
  logic                   armed_q, trig_q, trigW_q, cpsrValid_q, err_q;
  logic [31:0]            op1_q, op2_q, cpsrIn_q, mulAcc_q;
  logic [31:0]            addrW_q, dataW_q, cpsrOut_q;
  logic [5:0]             ctrl_q;
  logic [3:0]             type_q, rd_q;
  logic [4:0]             mulCnt_q;

  logic        readyS, ackS, isNop, isDp, isMul, isIllegal, isTest, isArith;
  logic        capture, leaveExec, doWrite, doFlags, addCin, overflow;
  logic [3:0]  opcode, nzcv;
  logic [31:0] addA, addB, result, mulNext;
  logic [32:0] sum;
  logic        unusedInputs;

  assign readyS       = readySync_q[SYNC_STAGES-1];
  assign ackS         = ackSync_q[SYNC_STAGES-1];
  assign opcode       = ctrl_q[3:0];
  assign isNop        = (type_q == TYPE_NOP);
  assign isDp         = (type_q == TYPE_DP);
  assign isMul        = MUL_ENABLE && (type_q == TYPE_MUL);
  assign isIllegal    = !(isNop || isDp || isMul);
  assign isTest       = (opcode[3:2] == 2'b10);
  assign mulNext      = mulAcc_q + (op2_q[0] ? op1_q : 32'd0);
  assign unusedInputs = ^{bus.srcDstIn[31:4], bus.dataIn3[31:6]};

  // Subtracts are formed as A + ~B + cin so sum[32] is directly NOT borrow.
  always_comb begin
    addA    = op1_q;
    addB    = op2_q;
    addCin  = 1'b0;
    isArith = 1'b1;
    case (opcode)
      4'h2, 4'hA: begin addB = ~op2_q; addCin = 1'b1; end
      4'h3:       begin addA = op2_q; addB = ~op1_q; addCin = 1'b1; end
      4'h4, 4'hB: addCin = 1'b0;
      4'h5:       addCin = cpsrIn_q[29];
      4'h6:       begin addB = ~op2_q; addCin = cpsrIn_q[29]; end
      4'h7:       begin addA = op2_q; addB = ~op1_q; addCin = cpsrIn_q[29]; end
      default:    isArith = 1'b0;
    endcase
    sum      = {1'b0, addA} + {1'b0, addB} + {32'd0, addCin};
    overflow = (addA[31] == addB[31]) && (sum[31] != addA[31]);
    case (opcode)
      4'h0, 4'h8: result = op1_q & op2_q;
      4'h1, 4'h9: result = op1_q ^ op2_q;
      4'hC:       result = op1_q | op2_q;
      4'hD:       result = op2_q;
      4'hE:       result = op1_q & ~op2_q;
      4'hF:       result = ~op2_q;
      default:    result = sum[31:0];
    endcase
    if (isMul)
      nzcv = {mulNext[31], mulNext == 32'd0, cpsrIn_q[29:28]};
    else
      nzcv = {result[31], result == 32'd0, isArith ? sum[32] : ctrl_q[5],
              isArith ? overflow : cpsrIn_q[28]};
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    leaveExec = 1'b0;
    doWrite   = 1'b0;
    doFlags   = 1'b0;
    case (state_q)
      IDLE: begin
        if (readyS && armed_q) begin
          capture = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!isMul || mulCnt_q == 5'd31) begin
          leaveExec = 1'b1;
          doWrite   = (isDp && !isTest) || isMul;
          doFlags   = (isDp && (ctrl_q[4] || isTest)) || (isMul && ctrl_q[4]);
          state_d   = doWrite ? WB_WAIT : IDLE;
        end
      end
      WB_WAIT: begin
        if (ackS == trigW_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The multiply walks op2 right and op1 left in place; DP never shifts them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      readySync_q <= '0;
      ackSync_q   <= '0;
      armed_q     <= 1'b1;
      trig_q      <= 1'b0;
      trigW_q     <= 1'b0;
      cpsrValid_q <= 1'b0;
      err_q       <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      cpsrIn_q    <= '0;
      mulAcc_q    <= '0;
      addrW_q     <= '0;
      dataW_q     <= '0;
      cpsrOut_q   <= '0;
      ctrl_q      <= '0;
      type_q      <= '0;
      rd_q        <= '0;
      mulCnt_q    <= '0;
    end else begin
      readySync_q <= {readySync_q[SYNC_STAGES-2:0], bus.readyIn};
      ackSync_q   <= {ackSync_q[SYNC_STAGES-2:0], bus.readyInW};
      cpsrValid_q <= 1'b0;
      if (!readyS) armed_q <= 1'b1;
      if (capture) begin
        op1_q    <= bus.dataIn1;
        op2_q    <= bus.dataIn2;
        ctrl_q   <= bus.dataIn3[5:0];
        cpsrIn_q <= bus.dataIn4;
        type_q   <= bus.typeIn;
        rd_q     <= bus.srcDstIn[3:0];
        mulAcc_q <= '0;
        mulCnt_q <= '0;
        armed_q  <= 1'b0;
        trig_q   <= ~trig_q;
      end
      if (state_q == EXEC && isMul) begin
        mulAcc_q <= mulNext;
        op1_q    <= op1_q << 1;
        op2_q    <= op2_q >> 1;
        mulCnt_q <= mulCnt_q + 5'd1;
      end
      if (leaveExec) begin
        if (isIllegal) err_q <= 1'b1;
        if (doWrite) begin
          addrW_q <= {28'd0, rd_q};
          dataW_q <= isMul ? mulNext : result;
          trigW_q <= ~trigW_q;
        end
        if (doFlags) begin
          cpsrOut_q   <= {nzcv, cpsrIn_q[27:0]};
          cpsrValid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.triggerOut  = trig_q;
  assign bus.triggerOutW = trigW_q;
  assign bus.addrW       = addrW_q;
  assign bus.dataW       = dataW_q;
  assign bus.cpsrOut     = cpsrOut_q;
  assign bus.cpsrValid   = cpsrValid_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.errOut      = err_q;

endmodule

// File: tb/tb_execute_unit.sv
// Randomised self-checking bench for execute_unit: a behavioural ARM ALU/multiply model
// feeds expected write and flag queues that a per-cycle compare process drains.
`timescale 1ns/1ps
module tb_execute_unit;
  localparam int SYNC_STAGES = 2;
  localparam longint MAX_S = 64'sd2147483647;
  localparam longint MIN_S = -64'sd2147483648;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  execute_unit_if bus();

  execute_unit #(.SYNC_STAGES(SYNC_STAGES), .MUL_ENABLE(1'b1)) dut (
    .clk(clk),
    .reset(rstN),
    .bus(bus)
  );

  int          checks = 0;
  int          failures = 0;
  int          cycle = 0;
  int          ackDelay = 0;
  int          lastWriteCyc = 0;
  int          lastBusy = 0;
  bit          modelErr = 1'b0;
  logic [63:0] writeQ[$];
  logic [31:0] flagQ[$];

  always @(posedge clk) cycle = cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Reference behaviour computed with wide signed/unsigned integer arithmetic.
  function automatic void model(input logic [3:0] typ, input logic [3:0] opc, input bit s,
                                input bit shc, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] cpsr, output bit wr, output logic [31:0] res,
                                output bit fl, output logic [31:0] cpsrExp, output bit ill);
    longint ua, ub, sa, sb, u, sv, bw;
    bit     c, v, isTest, logical, arith;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = cpsr[29];
    v = cpsr[28];
    wr = 1'b0; fl = 1'b0; ill = 1'b0; res = '0;
    logical = 1'b0; arith = 1'b0; u = 0; sv = 0; bw = 0;
    isTest = (opc >= 4'h8) && (opc <= 4'hB);
    case (typ)
      4'h0: ;
      4'h1: begin
        wr = !isTest;
        fl = s || isTest;
        case (opc)
          4'h0, 4'h8: begin res = a & b;  logical = 1'b1; end
          4'h1, 4'h9: begin res = a ^ b;  logical = 1'b1; end
          4'hC:       begin res = a | b;  logical = 1'b1; end
          4'hD:       begin res = b;      logical = 1'b1; end
          4'hE:       begin res = a & ~b; logical = 1'b1; end
          4'hF:       begin res = ~b;     logical = 1'b1; end
          4'h4, 4'hB, 4'h5: begin
            bw = (opc == 4'h5) ? longint'(cpsr[29]) : 0;
            u = ua + ub + bw;
            sv = sa + sb + bw;
            c = (u >= 64'sh1_0000_0000);
            arith = 1'b1;
          end
          4'h2, 4'hA, 4'h6: begin
            bw = (opc == 4'h6) ? 1 - longint'(cpsr[29]) : 0;
            u = ua - ub - bw;
            sv = sa - sb - bw;
            c = (u >= 0);
            arith = 1'b1;
          end
          default: begin
            bw = (opc == 4'h7) ? 1 - longint'(cpsr[29]) : 0;
            u = ub - ua - bw;
            sv = sb - sa - bw;
            c = (u >= 0);
            arith = 1'b1;
          end
        endcase
        if (arith) begin
          res = u[31:0];
          v = (sv > MAX_S) || (sv < MIN_S);
        end
        if (logical) c = shc;
      end
      4'h2: begin
        wr = 1'b1;
        fl = s;
        res = a * b;
      end
      default: ill = 1'b1;
    endcase
    cpsrExp = {res[31], res == 32'd0, c, v, cpsr[27:0]};
  endfunction

  function automatic logic [31:0] pickVal();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic applyStimulus(input logic [3:0] typ, input logic [3:0] opc, input bit s,
                               input bit shc, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] cpsr, input logic [3:0] rd, input int hold);
    bit          wr, fl, ill;
    logic [31:0] res, cpsrExp;
    logic        prevTrig, capTrig;
    int          lat, extra, capCyc, n;
    model(typ, opc, s, shc, a, b, cpsr, wr, res, fl, cpsrExp, ill);
    if (wr) writeQ.push_back({28'd0, rd, res});
    if (fl) flagQ.push_back(cpsrExp);
    if (ill) modelErr = 1'b1;
    bus.dataIn1  = a;
    bus.dataIn2  = b;
    bus.dataIn3  = {26'($urandom()), shc, s, opc};
    bus.dataIn4  = cpsr;
    bus.typeIn   = typ;
    bus.srcDstIn = {28'($urandom()), rd};
    prevTrig = bus.triggerOut;
    bus.readyIn = 1'b1;
    lat = 0;
    while (bus.triggerOut === prevTrig && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("capture_latency", lat, SYNC_STAGES + 1);
    capCyc = cycle;
    capTrig = bus.triggerOut;
    extra = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus.triggerOut !== capTrig) begin
        extra++;
        capTrig = bus.triggerOut;
      end
    end
    if (hold > 0) checkOutput("single_capture_while_held", extra, 0);
    bus.readyIn = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    lastBusy = n;
    checkOutput("returns_idle", {31'd0, bus.busy}, 0);
    if (wr) checkOutput("write_latency", lastWriteCyc - capCyc, (typ == 4'h2) ? 32 : 1);
    checkOutput("err_flag", {31'd0, bus.errOut}, {31'd0, modelErr});
    repeat (3) @(negedge clk);
  endtask

  // Regbank: acknowledges each write toggle after ackDelay extra cycles.
  initial begin
    int ackWait;
    bus.readyInW = 1'b0;
    ackWait = 0;
    forever begin
      @(negedge clk);
      if (!rstN) begin
        bus.readyInW = 1'b0;
        ackWait = 0;
      end else if (bus.triggerOutW !== bus.readyInW) begin
        if (ackWait >= ackDelay) begin
          bus.readyInW = bus.triggerOutW;
          ackWait = 0;
        end else begin
          ackWait++;
        end
      end
    end
  end

  // Compare process: every write toggle and flag pulse must match the next expectation.
  initial begin
    logic        prevTrigW;
    logic [31:0] heldAddr, heldData;
    logic [63:0] e;
    prevTrigW = 1'b0;
    heldAddr = '0;
    heldData = '0;
    forever begin
      @(negedge clk);
      if (!rstN) begin
        prevTrigW = bus.triggerOutW;
        heldAddr = bus.addrW;
        heldData = bus.dataW;
      end else begin
        if (bus.triggerOutW !== prevTrigW) begin
          prevTrigW = bus.triggerOutW;
          lastWriteCyc = cycle;
          heldAddr = bus.addrW;
          heldData = bus.dataW;
          if (writeQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_write: got addr %h data %h, required no write", bus.addrW, bus.dataW);
          end else begin
            e = writeQ.pop_front();
            checkOutput("write_addr", bus.addrW, e[63:32]);
            checkOutput("write_data", bus.dataW, e[31:0]);
          end
        end else begin
          checkOutput("write_addr_stable", bus.addrW, heldAddr);
          checkOutput("write_data_stable", bus.dataW, heldData);
        end
        if (bus.cpsrValid === 1'b1) begin
          if (flagQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_flags: got cpsr %h, required no update", bus.cpsrOut);
          end else begin
            checkOutput("cpsr_out", bus.cpsrOut, flagQ.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, required finish within 2 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          wr, fl, ill;
    logic [31:0] res, cpsrExp;
    logic        savedTrigW;
    logic        prevTrig;
    int          lat;

    bus.readyIn = 1'b0;
    bus.dataIn1 = '0; bus.dataIn2 = '0; bus.dataIn3 = '0; bus.dataIn4 = '0;
    bus.typeIn = '0; bus.srcDstIn = '0;
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ctrl", {27'd0, bus.triggerOut, bus.triggerOutW, bus.cpsrValid, bus.busy, bus.errOut}, 0);
    checkOutput("reset_addrW", bus.addrW, 0);
    checkOutput("reset_dataW", bus.dataW, 0);
    checkOutput("reset_cpsrOut", bus.cpsrOut, 0);
    @(negedge clk);
    rstN = 1'b1;
    repeat (2) @(negedge clk);

    model(4'h1, 4'h4, 1'b1, 1'b0, 32'd5, 32'd7, 32'd0, wr, res, fl, cpsrExp, ill);
    checkOutput("model_add_res", res, 32'd12);
    checkOutput("model_add_nzcv", {28'd0, cpsrExp[31:28]}, 32'h0);
    model(4'h1, 4'h2, 1'b1, 1'b0, 32'd3, 32'd5, 32'd0, wr, res, fl, cpsrExp, ill);
    checkOutput("model_sub_res", res, 32'hFFFF_FFFE);
    checkOutput("model_sub_nzcv", {28'd0, cpsrExp[31:28]}, 32'h8);
    model(4'h1, 4'hA, 1'b0, 1'b0, 32'd7, 32'd7, 32'd0, wr, res, fl, cpsrExp, ill);
    checkOutput("model_cmp_nzcv", {28'd0, cpsrExp[31:28]}, 32'h6);
    checkOutput("model_cmp_nowrite", {31'd0, wr}, 0);

    applyStimulus(4'h1, 4'h4, 1'b1, 1'b0, 32'd5, 32'd7, 32'd0, 4'd3, 0);
    checkOutput("add_addrW", bus.addrW, 32'd3);
    checkOutput("add_dataW", bus.dataW, 32'd12);
    checkOutput("add_first_write_toggle", {31'd0, bus.triggerOutW}, 1);
    checkOutput("add_first_capture_toggle", {31'd0, bus.triggerOut}, 1);
    checkOutput("add_nzcv", {28'd0, bus.cpsrOut[31:28]}, 32'h0);

    applyStimulus(4'h1, 4'h2, 1'b1, 1'b0, 32'd3, 32'd5, 32'd0, 4'd4, 0);
    checkOutput("sub_dataW", bus.dataW, 32'hFFFF_FFFE);
    checkOutput("sub_nzcv", {28'd0, bus.cpsrOut[31:28]}, 32'h8);

    savedTrigW = bus.triggerOutW;
    applyStimulus(4'h1, 4'hA, 1'b0, 1'b0, 32'd7, 32'd7, 32'd0, 4'd5, 0);
    checkOutput("cmp_no_write", {31'd0, bus.triggerOutW}, {31'd0, savedTrigW});
    checkOutput("cmp_nzcv", {28'd0, bus.cpsrOut[31:28]}, 32'h6);

    ackDelay = 10;
    applyStimulus(4'h2, 4'h0, 1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'd0, 4'd2, 0);
    checkOutput("mul_dataW", bus.dataW, 32'd0);
    checkOutput("mul_addrW", bus.addrW, 32'd2);
    checkOutput("mul_busy_span", {31'd0, lastBusy >= 42}, 1);
    ackDelay = 0;

    applyStimulus(4'h1, 4'hC, 1'b1, 1'b1, $urandom(), $urandom(), $urandom(), 4'd7, 50);
    applyStimulus(4'h1, 4'h4, 1'b0, 1'b0, 32'd100, 32'd23, 32'd0, 4'd15, 0);
    checkOutput("rd15_dataW", bus.dataW, 32'd123);

    applyStimulus(4'h7, 4'h4, 1'b1, 1'b0, 32'd1, 32'd2, 32'd0, 4'd1, 0);
    checkOutput("illegal_err", {31'd0, bus.errOut}, 1);
    applyStimulus(4'h0, 4'h4, 1'b1, 1'b0, 32'd1, 32'd2, 32'd0, 4'd1, 0);
    checkOutput("err_sticky", {31'd0, bus.errOut}, 1);

    for (int k = 0; k < 40; k++) begin
      int         r;
      logic [3:0] typ;
      r = $urandom_range(0, 9);
      typ = (r < 6) ? 4'h1 : (r < 8) ? 4'h2 : (r == 8) ? 4'h0 : 4'(3 + $urandom_range(0, 12));
      ackDelay = $urandom_range(0, 4);
      applyStimulus(typ, 4'($urandom()), 1'($urandom()), 1'($urandom()), pickVal(), pickVal(),
                    $urandom(), 4'($urandom()), 0);
    end
    ackDelay = 0;

    bus.dataIn1 = 32'h1234_5678;
    bus.dataIn2 = 32'h0000_0003;
    bus.dataIn3 = 32'h0000_0010;
    bus.dataIn4 = 32'h0;
    bus.typeIn = 4'h2;
    bus.srcDstIn = 32'd9;
    prevTrig = bus.triggerOut;
    bus.readyIn = 1'b1;
    lat = 0;
    while (bus.triggerOut === prevTrig && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("abort_capture_latency", lat, SYNC_STAGES + 1);
    bus.readyIn = 1'b0;
    repeat (9) @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    checkOutput("abort_reset_ctrl", {27'd0, bus.triggerOut, bus.triggerOutW, bus.cpsrValid, bus.busy, bus.errOut}, 0);
    checkOutput("abort_reset_addrW", bus.addrW, 0);
    checkOutput("abort_reset_dataW", bus.dataW, 0);
    checkOutput("abort_reset_cpsrOut", bus.cpsrOut, 0);
    modelErr = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("abort_idle", {31'd0, bus.busy}, 0);
    checkOutput("abort_no_write", {31'd0, bus.triggerOutW}, 0);

    applyStimulus(4'h1, 4'h4, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'd6, 0);
    checkOutput("post_reset_nzcv", {28'd0, bus.cpsrOut[31:28]}, 32'h6);

    checkOutput("write_queue_drained", writeQ.size(), 0);
    checkOutput("flag_queue_drained", flagQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
